// File: rtl/bios_fetch_pkg.sv
// bios_fetch_pkg: shared constants and output-buffer entry type for the BIOS fetch stage.
package bios_fetch_pkg;
  localparam int ADDR_W = 12;
  localparam logic [31:0] RESET_PC = 32'h4000_0000;
  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
`ifdef BIOS_FETCH_FAULT_EN
    logic        fault;
`endif
  } fetch_entry_t;
endpackage

// File: rtl/fetch_skid_fifo.sv
// fetch_skid_fifo: DEPTH-entry register FIFO holding fetched words until decode accepts them.
module fetch_skid_fifo
  import bios_fetch_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push_i,
  input  logic                         pop_i,
  input  logic                         flush_i,
  input  fetch_entry_t                 din_i,
  output fetch_entry_t                 dout_o,
  output logic                         valid_o,
  output logic [$clog2(DEPTH+1)-1:0]   count_o
);
  localparam int PW = DEPTH > 1 ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  fetch_entry_t mem_q [DEPTH];
  logic [PW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return p == PW'(DEPTH - 1) ? '0 : p + 1'b1;
  endfunction
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush_i) begin
      rd_q <= '0;
      wr_q <= '0;
      cnt_q <= '0;
    end else begin
      assert (!(push_i && cnt_q == CW'(DEPTH)));
      if (push_i) begin
        mem_q[wr_q] <= din_i;
        wr_q <= nxt(wr_q);
      end
      if (pop_i) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  assign dout_o = mem_q[rd_q];
  assign valid_o = cnt_q != '0;
  assign count_o = cnt_q;
endmodule

// File: rtl/bios_fetch_stage.sv
// bios_fetch_stage: BIOS ROM instruction fetch with a PC-tagged output buffer.
// BIOS_FETCH_FAULT_EN: PCs outside the BIOS window yield a faulting NOP instead of a ROM read.
module bios_fetch_stage #(
  parameter int          ADDR_W   = bios_fetch_pkg::ADDR_W,
  parameter logic [31:0] RESET_PC = bios_fetch_pkg::RESET_PC,
  parameter int          DEPTH    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [31:0]       redirect_pc,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [31:0]       out_inst,
  output logic [31:0]       out_pc,
`ifdef BIOS_FETCH_FAULT_EN
  output logic              out_fault,
`endif
  output logic              mem_en,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_dout
);
  localparam int CW = $clog2(DEPTH + 1);
  bios_fetch_pkg::fetch_entry_t push_e, head;
  logic [31:0] pc_q, pc_d, tag_q;
  logic inflight_q, issue, pop, push, in_win;
  logic [CW-1:0] count;
`ifdef BIOS_FETCH_FAULT_EN
  logic fault_q;
  assign in_win = pc_q[31:ADDR_W+2] == RESET_PC[31:ADDR_W+2];
  assign push_e = '{pc: tag_q, inst: fault_q ? bios_fetch_pkg::NOP_INST : mem_dout, fault: fault_q};
  assign out_fault = head.fault;
  always_ff @(posedge clk or posedge rst)
    if (rst) fault_q <= 1'b0;
    else if (issue) fault_q <= ~in_win;
`else
  assign in_win = 1'b1;
  assign push_e = '{pc: tag_q, inst: mem_dout};
`endif
  assign pop = out_valid & out_ready;
  // A slot is claimed at issue time, so buffered + in-flight can never exceed DEPTH
  assign issue = ~rst & ~redirect_valid & (32'(count) + 32'(inflight_q) < 32'(DEPTH) + 32'(pop));
  assign push = inflight_q & ~redirect_valid;
  assign mem_en = issue & in_win;
  assign mem_addr = pc_q[ADDR_W+1:2];
  assign pc_d = redirect_valid ? redirect_pc & ~32'h3 : pc_q + (issue ? 32'd4 : 32'd0);
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      pc_q <= RESET_PC;
      tag_q <= '0;
      inflight_q <= 1'b0;
    end else begin
      pc_q <= pc_d;
      inflight_q <= issue;
      if (issue) tag_q <= pc_q;
    end
  fetch_skid_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push_i(push),
    .pop_i(pop),
    .flush_i(redirect_valid),
    .din_i(push_e),
    .dout_o(head),
    .valid_o(out_valid),
    .count_o(count)
  );
  assign out_inst = head.inst;
  assign out_pc = head.pc;
endmodule

// File: tb/tb_bios_fetch_stage.sv
// tb_bios_fetch_stage: directed and random stimulus against a stream-level model of the fetch stage.
module tb_bios_fetch_stage;
  localparam logic [31:0] RPC = 32'h4000_0000;
  logic clk = 1'b0, rst, redirect_valid, out_ready, out_valid, mem_en;
  logic [31:0] redirect_pc, out_inst, out_pc, mem_dout = '0;
  logic [11:0] mem_addr;
`ifdef BIOS_FETCH_FAULT_EN
  logic out_fault;
`endif
  int checks = 0, errors = 0, outstanding = 0;
  logic [31:0] exp_pc, fetch_pc;

  bios_fetch_stage dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_ready(out_ready), .out_valid(out_valid), .out_inst(out_inst), .out_pc(out_pc),
`ifdef BIOS_FETCH_FAULT_EN
    .out_fault(out_fault),
`endif
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_dout(mem_dout)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] rom(input logic [11:0] a);
    return {a, 8'hA5, a} ^ 32'h1357_9BDF;
  endfunction

  always @(posedge clk) if (mem_en) mem_dout <= rom(mem_addr);

  function automatic logic in_win(input logic [31:0] pc);
    return (pc & 32'hFFFF_C000) == RPC;
  endfunction

  function automatic logic [31:0] exp_inst(input logic [31:0] pc);
`ifdef BIOS_FETCH_FAULT_EN
    if (!in_win(pc)) return 32'h0000_0013;
`endif
    return rom(pc[13:2]);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_pc = RPC;
    fetch_pc = RPC;
    outstanding = 0;
  endtask

  // Delivered stream must be contiguous from the last redirect target, one ROM word per PC
  task automatic tick();
    logic acc, red, en, of;
    logic [31:0] tgt, opc, oinst;
    logic [11:0] a;
    @(negedge clk);
    acc = out_valid & out_ready;
    red = redirect_valid;
    en = mem_en;
    a = mem_addr;
    tgt = redirect_pc;
    opc = out_pc;
    oinst = out_inst;
`ifdef BIOS_FETCH_FAULT_EN
    of = out_fault;
`else
    of = 1'b0;
`endif
    @(posedge clk);
    if (red) check("issue_in_redirect", 32'(en), 32'd0);
    if (en) begin
      check("fetch_addr", 32'(a), 32'(fetch_pc[13:2]));
      fetch_pc += 4;
      outstanding++;
    end
    if (acc) begin
      check("out_pc", opc, exp_pc);
      check("out_inst", oinst, exp_inst(exp_pc));
`ifdef BIOS_FETCH_FAULT_EN
      check("out_fault", 32'(of), 32'(!in_win(exp_pc)));
`else
      check("no_fault", 32'(of), 32'd0);
`endif
      exp_pc += 4;
      outstanding--;
    end
    if (red) begin
      exp_pc = tgt & ~32'h3;
      fetch_pc = tgt & ~32'h3;
      outstanding = 0;
    end
    check("outstanding_bound", 32'(outstanding <= 2), 32'd1);
    #1;
  endtask

  initial begin
    logic [31:0] r;
    rst = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_mem_en", 32'(mem_en), 32'd0);
    check("rst_out_pc", out_pc, 32'd0);
    check("rst_out_inst", out_inst, 32'd0);
    #2 rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("first_mem_en", 32'(mem_en), 32'd1);
    check("first_mem_addr", 32'(mem_addr), 32'h000);
    tick();
    check("no_early_valid", 32'(out_valid), 32'd0);
    tick();
    check("first_valid", 32'(out_valid), 32'd1);
    check("first_pc", out_pc, RPC);
    check("first_inst", out_inst, rom(12'h000));
    // stall decode: fetch must stop once the buffer quota is used
    out_ready = 1'b0;
    repeat (3) tick();
    check("stall_mem_en", 32'(mem_en), 32'd0);
    check("stall_head", out_pc, RPC);
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("throughput_valid", 32'(out_valid), 32'd1);
    end
    // redirect with buffer occupied and a read in flight
    out_ready = 1'b0;
    tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000_0103;
    #1;
    check("redirect_no_issue", 32'(mem_en), 32'd0);
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("flushed_valid", 32'(out_valid), 32'd0);
    check("redirect_mem_en", 32'(mem_en), 32'd1);
    check("redirect_mem_addr", 32'(mem_addr), 32'h040);
    tick();
    check("redirect_lat_valid", 32'(out_valid), 32'd0);
    tick();
    check("redirect_valid", 32'(out_valid), 32'd1);
    check("redirect_pc", out_pc, 32'h4000_0100);
    // redirect together with a pop
    repeat (3) tick();
    check("pop_redirect_head", 32'(out_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000_0200;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    check("pop_redirect_valid", 32'(out_valid), 32'd1);
    check("pop_redirect_pc", out_pc, 32'h4000_0200);
    // ROM index wraps at the top of the window
    redirect_valid = 1'b1;
    redirect_pc = 32'h4000_3FF8;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    for (int i = 0; i < 400; i++) begin
      out_ready = ($urandom % 10) < 7;
      redirect_valid = ($urandom % 20) == 0;
      r = $urandom;
`ifdef BIOS_FETCH_FAULT_EN
      redirect_pc = RPC | (r & 32'h3FFF);
`else
      redirect_pc = (r[31:30] == 2'b00) ? r : (RPC | (r & 32'h3FFF));
`endif
      tick();
    end
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();
    // asynchronous reset between edges
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", 32'(out_valid), 32'd0);
    check("async_rst_mem_en", 32'(mem_en), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    model_reset();
    #1;
    check("restart_mem_en", 32'(mem_en), 32'd1);
    check("restart_mem_addr", 32'(mem_addr), 32'h000);
    tick();
    tick();
    check("restart_valid", 32'(out_valid), 32'd1);
    check("restart_pc", out_pc, RPC);
`ifdef BIOS_FETCH_FAULT_EN
    redirect_valid = 1'b1;
    redirect_pc = 32'h1000_0000;
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b0;
    #1;
    check("fault_no_mem_en", 32'(mem_en), 32'd0);
    tick();
    tick();
    check("fault_valid", 32'(out_valid), 32'd1);
    check("fault_pc", out_pc, 32'h1000_0000);
    check("fault_inst", out_inst, 32'h0000_0013);
    check("fault_bit", 32'(out_fault), 32'd1);
    check("fault_mem_en", 32'(mem_en), 32'd0);
    redirect_valid = 1'b1;
    redirect_pc = RPC;
    out_ready = 1'b1;
    tick();
    redirect_valid = 1'b0;
    repeat (2) tick();
    check("unfault_valid", 32'(out_valid), 32'd1);
    check("unfault_pc", out_pc, RPC);
    check("unfault_bit", 32'(out_fault), 32'd0);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
